// File: rtl/timer_pkg.sv
// Shared definitions for the interval-timer slave and its Avalon-MM initiator:
// register word addresses, control words and the initiator state encoding.
package timer_pkg;

    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_PERIODH = 3'd3;
    localparam logic [2:0] TMR_SNAPL   = 3'd4;
    localparam logic [2:0] TMR_SNAPH   = 3'd5;

    // ITO | CONT | START
    localparam logic [15:0] CTRL_START = 16'h0007;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_ACK0,
        ST_WR_CTRL,
        ST_RUN,
        ST_ACK,
        ST_SN_WR,
        ST_SN_RL,
        ST_SN_WL,
        ST_SN_WH,
        ST_WR_STOP
    } state_t;

endpackage

// File: rtl/avmm_single_access.sv
// Single-cycle Avalon-MM access driver. A request lasts exactly one cycle;
// the slave returns read data one cycle after the read, flagged by rdata_valid.
module avmm_single_access (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        wr,
    input  logic [2:0]  addr,
    input  logic [15:0] wdata,
    output logic [2:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [15:0] av_writedata,
    input  logic [15:0] av_readdata,
    output logic [15:0] rdata,
    output logic        rdata_valid
);

    // Bus pins follow the request combinationally so a reset drops them at once.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        av_chipselect = 1'b0;
        av_write_n    = 1'b1;
        av_address    = 3'd0;
        av_writedata  = 16'h0000;
        if (req) begin
            av_chipselect = 1'b1;
            av_address    = addr;
            if (wr) begin
                av_write_n   = 1'b0;
                av_writedata = wdata;
            end
        end
    end

    // Remember that a read went out so the next cycle's readdata is flagged.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset_n) rdata_valid <= 1'b0;
        else          rdata_valid <= req && !wr;
    end

    assign rdata = av_readdata;

endmodule

// File: rtl/timer_tick_master.sv
// Avalon-MM initiator that programs the interval timer, services its irq,
// counts ticks and reads counter snapshots without a CPU.
module timer_tick_master
    import timer_pkg::*;
#(
    parameter logic [31:0] DEF_PERIOD = 32'd49999,
    parameter int          TICK_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_start,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_stop,
    input  logic              snap_req,
    output logic              busy,
    output logic              running,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snapshot,
    output logic              snap_valid,
    output logic [2:0]        av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [15:0]       av_writedata,
    input  logic [15:0]       av_readdata,
    input  logic              irq_in
);

    state_t      state_q, state_d;
    logic [31:0] period_q;
    logic        stop_pend, snap_pend;
    logic [15:0] snap_lo;

    logic        req, wr;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        ack_go;

    avmm_single_access u_bus (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .wr            (wr),
        .addr          (addr),
        .wdata         (wdata),
        .av_address    (av_address),
        .av_chipselect (av_chipselect),
        .av_write_n    (av_write_n),
        .av_writedata  (av_writedata),
        .av_readdata   (av_readdata),
        .rdata         (rdata),
        .rdata_valid   (rdata_valid)
    );

    // Next-state selection and the bus access belonging to the current state.
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        wr      = 1'b0;
        addr    = TMR_STATUS;
        wdata   = 16'h0000;
        unique case (state_q)
            ST_IDLE: begin
                // A stop in the same cycle as a start cancels the start.
                if (cfg_stop)       state_d = ST_IDLE;
                else if (cfg_start) state_d = ST_WR_PL;
                else if (snap_pend) state_d = ST_SN_WR;
            end
            ST_WR_PL: begin
                req = 1'b1; wr = 1'b1; addr = TMR_PERIODL; wdata = period_q[15:0];
                state_d = ST_WR_PH;
            end
            ST_WR_PH: begin
                req = 1'b1; wr = 1'b1; addr = TMR_PERIODH; wdata = period_q[31:16];
                state_d = ST_WR_ACK0;
            end
            ST_WR_ACK0: begin
                req = 1'b1; wr = 1'b1; addr = TMR_STATUS;
                state_d = ST_WR_CTRL;
            end
            ST_WR_CTRL: begin
                req = 1'b1; wr = 1'b1; addr = TMR_CONTROL; wdata = CTRL_START;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop_pend)      state_d = ST_WR_STOP;
                else if (irq_in)    state_d = ST_ACK;
                else if (snap_pend) state_d = ST_SN_WR;
            end
            ST_ACK: begin
                req = 1'b1; wr = 1'b1; addr = TMR_STATUS;
                state_d = ST_RUN;
            end
            ST_SN_WR: begin
                req = 1'b1; wr = 1'b1; addr = TMR_SNAPL;
                state_d = ST_SN_RL;
            end
            ST_SN_RL: begin
                req = 1'b1; addr = TMR_SNAPL;
                state_d = ST_SN_WL;
            end
            ST_SN_WL: begin
                req = 1'b1; addr = TMR_SNAPH;
                state_d = ST_SN_WH;
            end
            ST_SN_WH: begin
                // Snapshots may be taken from IDLE as well; return where we came from.
                state_d = running ? ST_RUN : ST_IDLE;
            end
            ST_WR_STOP: begin
                req = 1'b1; wr = 1'b1; addr = TMR_CONTROL; wdata = CTRL_STOP;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ack_go = (state_q == ST_RUN) && (state_d == ST_ACK);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Latch the load value on an accepted start; zero selects the default period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q <= 32'd0;
        end else if (state_q == ST_IDLE && cfg_start && !cfg_stop) begin
            period_q <= (cfg_period == 32'd0) ? DEF_PERIOD : cfg_period;
        end
    end

    // Sticky command flags; a stop has nothing to act on while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stop_pend <= 1'b0;
            snap_pend <= 1'b0;
        end else begin
            if (state_q == ST_IDLE || state_d == ST_WR_STOP) stop_pend <= 1'b0;
            else if (cfg_stop)                                 stop_pend <= 1'b1;

            if (snap_req)                  snap_pend <= 1'b1;
            else if (state_d == ST_SN_WR)  snap_pend <= 1'b0;
        end
    end

    // Running flag, tick pulse and tick counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running    <= 1'b0;
            tick       <= 1'b0;
            tick_count <= '0;
        end else begin
            if (state_q == ST_WR_CTRL)      running <= 1'b1;
            else if (state_q == ST_WR_STOP) running <= 1'b0;

            tick <= ack_go;

            if (state_q == ST_WR_CTRL) tick_count <= '0;
            else if (ack_go)           tick_count <= tick_count + TICK_W'(1);
        end
    end

    // Assemble the snapshot from the two read-data beats.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_lo    <= 16'h0000;
            snapshot   <= 32'd0;
            snap_valid <= 1'b0;
        end else begin
            if (state_q == ST_SN_WL && rdata_valid) snap_lo <= rdata;
            snap_valid <= (state_q == ST_SN_WH) && rdata_valid;
            if (state_q == ST_SN_WH && rdata_valid) snapshot <= {rdata, snap_lo};
        end
    end

    assign busy = !(state_q == ST_IDLE || state_q == ST_RUN) || stop_pend || snap_pend;

endmodule

// File: tb/tb_timer_tick_master.sv
// Directed bench for timer_tick_master with a minimal slave model
// (sticky irq cleared by a status write, snapshot registers, 1-cycle readdata).
module tb_timer_tick_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_start, cfg_stop, snap_req;
    logic [31:0] cfg_period;
    logic        busy, running, tick, snap_valid;
    logic [31:0] tick_count, snapshot;
    logic [2:0]  av_address;
    logic        av_chipselect, av_write_n;
    logic [15:0] av_writedata, av_readdata;
    logic        irq_in;

    logic        irq_set;
    logic        irq_lvl;
    logic [31:0] cnt_val;
    logic [31:0] snap_reg;
    int          wr_count;
    int          wr_base;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    timer_tick_master dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_start     (cfg_start),
        .cfg_period    (cfg_period),
        .cfg_stop      (cfg_stop),
        .snap_req      (snap_req),
        .busy          (busy),
        .running       (running),
        .tick          (tick),
        .tick_count    (tick_count),
        .snapshot      (snapshot),
        .snap_valid    (snap_valid),
        .av_address    (av_address),
        .av_chipselect (av_chipselect),
        .av_write_n    (av_write_n),
        .av_writedata  (av_writedata),
        .av_readdata   (av_readdata),
        .irq_in        (irq_in)
    );

    // Slave model: level irq held until a status write, snapshot capture, registered readdata.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_lvl     <= 1'b0;
            snap_reg    <= 32'd0;
            av_readdata <= 16'h0000;
            wr_count    <= 0;
        end else begin
            if (av_chipselect && !av_write_n && av_address == 3'd0) irq_lvl <= 1'b0;
            else if (irq_set)                                        irq_lvl <= 1'b1;
            if (av_chipselect && !av_write_n && av_address == 3'd4) snap_reg <= cnt_val;
            if (av_chipselect && av_write_n && av_address == 3'd4)      av_readdata <= snap_reg[15:0];
            else if (av_chipselect && av_write_n && av_address == 3'd5) av_readdata <= snap_reg[31:16];
            else                                                        av_readdata <= 16'h0000;
            if (av_chipselect) wr_count <= wr_count + 1;
        end
    end

    assign irq_in = irq_lvl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_bus(input string tag, input logic cs, input logic wn,
                             input logic [2:0] a, input logic [15:0] wd);
        check({tag, "_cs"},   32'(av_chipselect), 32'(cs));
        check({tag, "_wn"},   32'(av_write_n),    32'(wn));
        check({tag, "_addr"}, 32'(av_address),    32'(a));
        check({tag, "_wd"},   32'(av_writedata),  32'(wd));
    endtask

    initial begin
        reset_n = 1'b0; cfg_start = 1'b0; cfg_period = 32'd0; cfg_stop = 1'b0;
        snap_req = 1'b0; irq_set = 1'b0; cnt_val = 32'h0003_0005; wr_base = 0;
        step(2);
        check("rst_running",  32'(running),    32'd0);
        check("rst_busy",     32'(busy),       32'd0);
        check("rst_tick",     32'(tick),       32'd0);
        check("rst_tcount",   tick_count,      32'd0);
        check("rst_snapshot", snapshot,        32'd0);
        check("rst_svalid",   32'(snap_valid), 32'd0);
        check_bus("rst", 1'b0, 1'b1, 3'd0, 16'h0000);
        reset_n = 1'b1;
        step(1);

        // Start with period 9: four back-to-back writes.
        cfg_start = 1'b1; cfg_period = 32'd9;
        step(1);
        cfg_start = 1'b0; cfg_period = 32'd0;
        check_bus("wr_pl", 1'b1, 1'b0, 3'd2, 16'h0009);
        check("wr_pl_busy", 32'(busy), 32'd1);
        step(1);
        check_bus("wr_ph", 1'b1, 1'b0, 3'd3, 16'h0000);
        step(1);
        check("wr_ack0_cs",   32'(av_chipselect), 32'd1);
        check("wr_ack0_wn",   32'(av_write_n),    32'd0);
        check("wr_ack0_addr", 32'(av_address),    32'd0);
        step(1);
        check_bus("wr_ctrl", 1'b1, 1'b0, 3'd1, 16'h0007);
        check("wr_ctrl_running", 32'(running), 32'd0);
        step(1);
        check("run_cs",      32'(av_chipselect), 32'd0);
        check("run_running", 32'(running),       32'd1);
        check("run_busy",    32'(busy),          32'd0);
        check("run_tcount",  tick_count,         32'd0);

        // irq -> tick one cycle later, status cleared, single count.
        irq_set = 1'b1;
        step(1);
        irq_set = 1'b0;
        check("irq_seen", 32'(irq_in), 32'd1);
        check("irq_tick0", 32'(tick), 32'd0);
        step(1);
        check("ack_tick",   32'(tick), 32'd1);
        check("ack_tcount", tick_count, 32'd1);
        check_bus("ack", 1'b1, 1'b0, 3'd0, 16'h0000);
        step(1);
        check("post_ack_tick", 32'(tick),          32'd0);
        check("post_ack_irq",  32'(irq_in),        32'd0);
        check("post_ack_cs",   32'(av_chipselect), 32'd0);
        step(1);
        check("no_double_tick",   32'(tick), 32'd0);
        check("no_double_tcount", tick_count, 32'd1);

        // Snapshot in RUN with irq arriving during SN_RL.
        snap_req = 1'b1;
        step(1);
        snap_req = 1'b0;
        check("snap_pend_busy", 32'(busy), 32'd1);
        check("snap_pend_cs", 32'(av_chipselect), 32'd0);
        step(1);
        check_bus("sn_wr", 1'b1, 1'b0, 3'd4, 16'h0000);
        irq_set = 1'b1;
        step(1);
        irq_set = 1'b0;
        check("sn_rl_cs",   32'(av_chipselect), 32'd1);
        check("sn_rl_wn",   32'(av_write_n),    32'd1);
        check("sn_rl_addr", 32'(av_address),    32'd4);
        check("sn_rl_irq",  32'(irq_in),        32'd1);
        step(1);
        check("sn_wl_wn",   32'(av_write_n), 32'd1);
        check("sn_wl_addr", 32'(av_address), 32'd5);
        check("sn_wl_sv",   32'(snap_valid), 32'd0);
        step(1);
        check("sn_wh_cs",   32'(av_chipselect), 32'd0);
        check("sn_wh_sv",   32'(snap_valid),    32'd0);
        check("sn_wh_tick", 32'(tick),          32'd0);
        step(1);
        check("snap_valid", 32'(snap_valid), 32'd1);
        check("snap_value", snapshot,        32'h0003_0005);
        check("snap_tick0", 32'(tick),       32'd0);
        check("snap_tcount", tick_count,     32'd1);
        step(1);
        check("late_tick",   32'(tick),       32'd1);
        check("late_tcount", tick_count,      32'd2);
        check("late_sv",     32'(snap_valid), 32'd0);
        check_bus("late_ack", 1'b1, 1'b0, 3'd0, 16'h0000);
        step(1);
        check("late_tick_once", 32'(tick), 32'd0);
        step(2);
        check("late_tcount_hold", tick_count, 32'd2);

        // Stop from RUN.
        cfg_stop = 1'b1;
        step(1);
        cfg_stop = 1'b0;
        check("stop_pend_busy", 32'(busy), 32'd1);
        step(1);
        check_bus("wr_stop", 1'b1, 1'b0, 3'd1, 16'h0008);
        check("wr_stop_running", 32'(running), 32'd1);
        step(1);
        check("idle_running", 32'(running),       32'd0);
        check("idle_busy",    32'(busy),          32'd0);
        check("idle_cs",      32'(av_chipselect), 32'd0);

        // Start and stop together in IDLE: nothing happens.
        wr_base = wr_count;
        cfg_start = 1'b1; cfg_stop = 1'b1; cfg_period = 32'd9;
        step(1);
        cfg_start = 1'b0; cfg_stop = 1'b0; cfg_period = 32'd0;
        step(3);
        check("ss_no_bus",  32'(wr_count - wr_base), 32'd0);
        check("ss_running", 32'(running), 32'd0);
        check("ss_busy",    32'(busy),    32'd0);

        // Zero period selects default; reset in WR_PH drops the bus at once.
        cfg_start = 1'b1; cfg_period = 32'd0;
        step(1);
        cfg_start = 1'b0;
        check_bus("def_pl", 1'b1, 1'b0, 3'd2, 16'hC34F);
        step(1);
        check_bus("def_ph", 1'b1, 1'b0, 3'd3, 16'h0000);
        reset_n = 1'b0;
        #1;
        check("mid_rst_cs",     32'(av_chipselect), 32'd0);
        check("mid_rst_wn",     32'(av_write_n),    32'd1);
        check("mid_rst_addr",   32'(av_address),    32'd0);
        check("mid_rst_tcount", tick_count,         32'd0);
        check("mid_rst_busy",   32'(busy),          32'd0);
        step(1);
        reset_n = 1'b1;
        step(1);

        // Snapshot requested from IDLE returns to IDLE.
        cnt_val = 32'h0001_ABCD;
        snap_req = 1'b1;
        step(1);
        snap_req = 1'b0;
        step(1);
        check_bus("idle_sn_wr", 1'b1, 1'b0, 3'd4, 16'h0000);
        step(4);
        check("idle_snap_valid", 32'(snap_valid), 32'd1);
        check("idle_snap_value", snapshot,        32'h0001_ABCD);
        check("idle_snap_run",   32'(running),    32'd0);
        check("idle_snap_busy",  32'(busy),       32'd0);
        check("idle_snap_cs",    32'(av_chipselect), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
